// File: rtl/int_to_float_conv_if.sv
// int_to_float_conv_if: start/done handshake bundle for the integer-to-float converter.
//   start   : request, sampled only while the converter is idle
//   sign_in : operand sign (1 = negative)
//   mag_in  : unsigned operand magnitude, DATA_W bits
//   busy    : conversion in progress
//   done    : one-cycle pulse, result valid in that cycle
//   result  : packed single-precision float {sign, exp[7:0], frac[22:0]}
// master modport is the requester side, slave modport is the converter side.
interface int_to_float_conv_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              sign_in;
  logic [DATA_W-1:0] mag_in;
  logic              busy;
  logic              done;
  logic [31:0]       result;

  modport master (
    output start,
    output sign_in,
    output mag_in,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  sign_in,
    input  mag_in,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/int_to_float_conv.sv
// int_to_float_conv: iterative sign-magnitude integer to IEEE-754 single-precision converter.
// Normalizes one bit per clock, then rounds and packs the float.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   conv : int_to_float_conv_if.slave (start, sign_in, mag_in, busy, done, result)
// Optional build macro ROUND_NEAREST_EN: round-to-nearest-even when defined,
// truncation when undefined.
module int_to_float_conv #(
  parameter int unsigned DATA_W = 32  // legal range 24..32
) (
  input logic                  clk,
  input logic                  rst,
  int_to_float_conv_if.slave   conv
);

  localparam int unsigned LzW = $clog2(DATA_W);
  // Exponent of an operand whose MSB already sits in the top bit.
  localparam logic [7:0] ExpTop = 8'(127 + DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e            r_state, w_state_next;
  logic              r_sign, w_sign_next;
  logic [DATA_W-1:0] r_mag, w_mag_next;
  logic [LzW-1:0]    r_lz, w_lz_next;
  logic [31:0]       r_result, w_result_next;

  logic [22:0] w_frac;
  logic [7:0]  w_exp;
  logic        w_round_up;
  logic [23:0] w_frac_sum;
  logic [7:0]  w_exp_rnd;

  // Normalized register: bit DATA_W-1 is the hidden one, the next 23 bits are the fraction.
  assign w_frac = r_mag[DATA_W-2 -: 23];
  assign w_exp  = ExpTop - 8'(r_lz);

`ifdef ROUND_NEAREST_EN
  logic w_guard, w_sticky;
  if (DATA_W >= 26) begin : g_gs_full
    assign w_guard  = r_mag[DATA_W-25];
    assign w_sticky = |r_mag[DATA_W-26:0];
  end else if (DATA_W == 25) begin : g_gs_guard
    assign w_guard  = r_mag[0];
    assign w_sticky = 1'b0;
  end else begin : g_gs_none
    assign w_guard  = 1'b0;
    assign w_sticky = 1'b0;
  end
  assign w_round_up = w_guard & (w_sticky | w_frac[0]);
`else
  assign w_round_up = 1'b0;
`endif

  // A carry out of the fraction leaves it all-zero and bumps the exponent.
  assign w_frac_sum = {1'b0, w_frac} + 24'(w_round_up);
  assign w_exp_rnd  = w_exp + 8'(w_frac_sum[23]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_lz     <= '0;
      r_result <= 32'h0;
    end else begin
      r_state  <= w_state_next;
      r_sign   <= w_sign_next;
      r_mag    <= w_mag_next;
      r_lz     <= w_lz_next;
      r_result <= w_result_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_sign_next   = r_sign;
    w_mag_next    = r_mag;
    w_lz_next     = r_lz;
    w_result_next = r_result;
    unique case (r_state)
      StIdle: begin
        if (conv.start) begin
          w_sign_next = conv.sign_in;
          w_mag_next  = conv.mag_in;
          w_lz_next   = '0;
          if (conv.mag_in == '0) begin
            // Zero always packs as +0 regardless of sign.
            w_result_next = 32'h0;
            w_state_next  = StDone;
          end else begin
            w_state_next = StNorm;
          end
        end
      end
      StNorm: begin
        if (!r_mag[DATA_W-1]) begin
          w_mag_next = {r_mag[DATA_W-2:0], 1'b0};
          w_lz_next  = r_lz + LzW'(1);
        end else begin
          w_state_next = StRound;
        end
      end
      StRound: begin
        w_result_next = {r_sign, w_exp_rnd, w_frac_sum[22:0]};
        w_state_next  = StDone;
      end
      StDone: begin
        // Any start seen here is dropped; acceptance resumes next cycle.
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign conv.busy   = (r_state == StNorm) || (r_state == StRound);
  assign conv.done   = (r_state == StDone);
  assign conv.result = r_result;

endmodule
